// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor that processes CHUNK bits of A and B on each clock.
// Defining SEQ_ADD_SUB_OVF_EN adds the registered signed-overflow output OV.
module seq_add_sub #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SnA,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
`ifdef SEQ_ADD_SUB_OVF_EN
  output logic             OV,
`endif
  output logic             BUSY,
  output logic             DONE
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_y;
  logic             r_co;
  logic             r_busy;
  logic             r_done;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_shadowNext;
  logic             w_last;

  // Operands shift right each RUN cycle, so the active chunk is always the low CHUNK bits.
  assign w_sum  = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_last = (r_cnt == LAST);

  // Partial results enter the shadow from the top, so after N chunks it is in bit order.
  if (N > 1) begin : g_multi
    logic [WIDTH-CHUNK-1:0] r_shadow;

    assign w_shadowNext = {w_sum[CHUNK-1:0], r_shadow};

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_shadow <= '0;
      end else if (r_state == S_RUN) begin
        r_shadow <= w_shadowNext[WIDTH-1:CHUNK];
      end
    end
  end else begin : g_single
    assign w_shadowNext = w_sum[CHUNK-1:0];
  end

`ifdef SEQ_ADD_SUB_OVF_EN
  logic r_ov;
  logic w_msbCarryIn;

  assign w_msbCarryIn = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_sum[CHUNK-1];
  assign OV = r_ov;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ov <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_ov <= w_msbCarryIn ^ w_sum[CHUNK];
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_co    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // Subtraction is A + ~B + 1, so the inversion and the +1 are folded in here.
          if (START) begin
            r_a     <= A;
            r_b     <= B ^ {WIDTH{SnA}};
            r_carry <= SnA;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_sum[CHUNK];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_y     <= w_shadowNext;
            r_co    <= w_sum[CHUNK];
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Y    = r_y;
  assign CO   = r_co;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_seq_add_sub.sv
// Self-checking bench for seq_add_sub: a 64/8 instance against an arithmetic reference model,
// plus a 32/32 single-cycle instance. OV is checked when SEQ_ADD_SUB_OVF_EN is defined.
module tb_seq_add_sub;

  localparam int W = 64;
  localparam int C = 8;
  localparam int N = W / C;
`ifdef SEQ_ADD_SUB_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic         CLK   = 1'b0;
  logic         RST   = 1'b1;
  logic         START = 1'b0;
  logic         SnA   = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic [W-1:0] Y;
  logic         CO, BUSY, DONE;

  logic         START2 = 1'b0;
  logic         SnA2   = 1'b0;
  logic [31:0]  A2     = '0;
  logic [31:0]  B2     = '0;
  logic [31:0]  Y2;
  logic         CO2, BUSY2, DONE2;
  logic         obsOv, obsOv2;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] holdY  = '0;
  logic         holdCO = 1'b0;
  logic         holdOV = 1'b0;

  always #5 CLK = ~CLK;

  seq_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SnA(SnA), .A(A), .B(B),
    .Y(Y), .CO(CO),
`ifdef SEQ_ADD_SUB_OVF_EN
    .OV(obsOv),
`endif
    .BUSY(BUSY), .DONE(DONE)
  );

  seq_add_sub #(.WIDTH(32), .CHUNK(32)) dut32 (
    .CLK(CLK), .RST(RST), .START(START2), .SnA(SnA2), .A(A2), .B(B2),
    .Y(Y2), .CO(CO2),
`ifdef SEQ_ADD_SUB_OVF_EN
    .OV(obsOv2),
`endif
    .BUSY(BUSY2), .DONE(DONE2)
  );

`ifndef SEQ_ADD_SUB_OVF_EN
  assign obsOv  = 1'b0;
  assign obsOv2 = 1'b0;
`endif

  // Reference: plain wrap-around arithmetic; returns {ov, co, y}.
  function automatic logic [W+1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
    logic [W:0]   s;
    logic [W-1:0] y;
    logic         co, ov;
    s = {1'b0, a} + {1'b0, b};
    if (sub) begin
      y  = a - b;
      co = (a >= b);
      ov = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
    end else begin
      y  = s[W-1:0];
      co = s[W];
      ov = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
    end
    return {ov & OVF, co, y};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    A = a; B = b; SnA = sub; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic test_reset;
    A = 64'h1234; B = 64'h5678; START = 1'b1; RST = 1'b1;
    tick();
    tick();
    checks++;
    if ({obsOv, CO, Y, BUSY, DONE} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got ov=%b co=%b y=%h busy=%b done=%b, expected all 0",
               obsOv, CO, Y, BUSY, DONE);
    end
    RST = 1'b0; START = 1'b0;
    tick();
    checks++;
    if ({BUSY, DONE, BUSY2, DONE2} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_idle: got busy/done=%b%b busy2/done2=%b%b, expected 0000",
               BUSY, DONE, BUSY2, DONE2);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vs [4];
    logic [W+1:0] exp;
    va = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd7, 64'h7FFF_FFFF_FFFF_FFFF};
    vb = '{64'd1, 64'd7, 64'd5, 64'd1};
    vs = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int v = 0; v < 4; v++) begin
      exp = refModel(va[v], vb[v], vs[v]);
      startOp(va[v], vb[v], vs[v]);
      for (int e = 0; e <= N; e++) begin
        if (e > 0) tick();
        if (e < N) begin
          checks++;
          if ({BUSY, DONE} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL directed%0d_busy cycle %0d: got busy/done=%b, expected 10",
                     v, e, {BUSY, DONE});
          end
          checks++;
          if ({obsOv, CO, Y} !== {holdOV, holdCO, holdY}) begin
            errors++;
            $display("[TB] FAIL directed%0d_hold cycle %0d: got %b %b %h, expected %b %b %h",
                     v, e, obsOv, CO, Y, holdOV, holdCO, holdY);
          end
        end else begin
          checks++;
          if ({BUSY, DONE} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL directed%0d_done: got busy/done=%b, expected 01", v, {BUSY, DONE});
          end
          checks++;
          if ({obsOv, CO, Y} !== exp) begin
            errors++;
            $display("[TB] FAIL directed%0d_result: got ov=%b co=%b y=%h, expected ov=%b co=%b y=%h",
                     v, obsOv, CO, Y, exp[W+1], exp[W], exp[W-1:0]);
          end
          {holdOV, holdCO, holdY} = exp;
        end
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    logic         sub;
    logic [W+1:0] exp;
    int           extra;
    for (int i = 0; i < 16; i++) begin
      a   = {$urandom, $urandom};
      b   = (i < 2) ? a : {$urandom, $urandom};
      sub = (i == 0) ? 1'b1 : 1'($urandom % 2);
      exp = refModel(a, b, sub);
      startOp(a, b, sub);
      for (int e = 1; e <= N; e++) begin
        A = {$urandom, $urandom}; B = {$urandom, $urandom}; SnA = 1'($urandom % 2);
        tick();
        if (e == N - 1) begin
          checks++;
          if (DONE !== 1'b0) begin
            errors++;
            $display("[TB] FAIL random%0d_early_done: got done=%b, expected 0", i, DONE);
          end
        end
      end
      checks++;
      if ({BUSY, DONE, obsOv, CO, Y} !== {2'b01, exp}) begin
        errors++;
        $display("[TB] FAIL random%0d a=%h b=%h sub=%b: got busy/done=%b%b ov=%b co=%b y=%h, expected 01 %b %b %h",
                 i, a, b, sub, BUSY, DONE, obsOv, CO, Y, exp[W+1], exp[W], exp[W-1:0]);
      end
      {holdOV, holdCO, holdY} = exp;
      extra = int'($urandom_range(0, 2));
      for (int k = 0; k < extra; k++) begin
        tick();
        checks++;
        if ({DONE, obsOv, CO, Y} !== {1'b1, exp}) begin
          errors++;
          $display("[TB] FAIL random%0d_hold: got done=%b y=%h, expected done=1 y=%h",
                   i, DONE, Y, exp[W-1:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W+1:0] exp1, exp3;
    exp1 = refModel(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
    exp3 = refModel(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001, 1'b1);
    startOp(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
    for (int e = 1; e <= N; e++) begin
      if (e == 3) begin
        A = 64'hDEAD_BEEF_0000_0000; B = 64'h0000_0000_FEED_FACE; SnA = 1'b1; START = 1'b1;
      end
      tick();
      START = 1'b0;
      if (e < N) begin
        checks++;
        if ({BUSY, DONE} !== 2'b10) begin
          errors++;
          $display("[TB] FAIL ignore_busy cycle %0d: got busy/done=%b, expected 10", e, {BUSY, DONE});
        end
      end
    end
    checks++;
    if ({BUSY, DONE, obsOv, CO, Y} !== {2'b01, exp1}) begin
      errors++;
      $display("[TB] FAIL ignore_result: got done=%b co=%b y=%h, expected done=1 co=%b y=%h",
               DONE, CO, Y, exp1[W], exp1[W-1:0]);
    end
    tick();
    checks++;
    if ({DONE, Y} !== {1'b1, exp1[W-1:0]}) begin
      errors++;
      $display("[TB] FAIL ignore_settled: got done=%b y=%h, expected done=1 y=%h", DONE, Y, exp1[W-1:0]);
    end
    startOp(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001, 1'b1);
    checks++;
    if ({BUSY, DONE, obsOv, CO, Y} !== {2'b10, exp1}) begin
      errors++;
      $display("[TB] FAIL b2b_restart: got busy/done=%b%b y=%h, expected 10 y=%h",
               BUSY, DONE, Y, exp1[W-1:0]);
    end
    for (int e = 1; e <= N; e++) tick();
    checks++;
    if ({BUSY, DONE, obsOv, CO, Y} !== {2'b01, exp3}) begin
      errors++;
      $display("[TB] FAIL b2b_result: got done=%b co=%b y=%h, expected done=1 co=%b y=%h",
               DONE, CO, Y, exp3[W], exp3[W-1:0]);
    end
    {holdOV, holdCO, holdY} = exp3;
  endtask

  task automatic test_reset_mid_run;
    logic [W+1:0] exp;
    startOp({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    for (int e = 0; e < 4; e++) tick();
    RST = 1'b1; START = 1'b1;
    tick();
    RST = 1'b0; START = 1'b0;
    checks++;
    if ({BUSY, DONE, obsOv, CO, Y} !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got busy/done=%b%b ov=%b co=%b y=%h, expected all 0",
               BUSY, DONE, obsOv, CO, Y);
    end
    exp = refModel(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0);
    startOp(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0);
    for (int e = 1; e <= N; e++) tick();
    checks++;
    if ({BUSY, DONE, obsOv, CO, Y} !== {2'b01, exp}) begin
      errors++;
      $display("[TB] FAIL midrun_restart: got done=%b ov=%b co=%b y=%h, expected done=1 ov=%b co=%b y=%h",
               DONE, obsOv, CO, Y, exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_single_chunk;
    logic [31:0] a, b, y;
    A2 = 32'h8000_0000; B2 = 32'h8000_0000; SnA2 = 1'b0; START2 = 1'b1;
    tick();
    START2 = 1'b0;
    checks++;
    if ({BUSY2, DONE2} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL single_busy: got busy/done=%b%b, expected 10", BUSY2, DONE2);
    end
    tick();
    checks++;
    if ({DONE2, obsOv2, CO2, Y2} !== {1'b1, OVF, 1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL single_add: got done=%b ov=%b co=%b y=%h, expected done=1 ov=%b co=1 y=0",
               DONE2, obsOv2, CO2, Y2, OVF);
    end
    a = $urandom; b = $urandom;
    y = a - b;
    A2 = a; B2 = b; SnA2 = 1'b1; START2 = 1'b1;
    tick();
    START2 = 1'b0;
    tick();
    checks++;
    if ({DONE2, CO2, Y2} !== {1'b1, (a >= b), y}) begin
      errors++;
      $display("[TB] FAIL single_sub a=%h b=%h: got done=%b co=%b y=%h, expected done=1 co=%b y=%h",
               a, b, DONE2, CO2, Y2, (a >= b), y);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_single_chunk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
